// File: rtl/sym_game_ctrl.sv
// Round sequencer for the symbol-counting game: idle/countdown/play/done FSM,
// generator speed control and saturating hit/miss scoring.
module sym_game_ctrl #(
   parameter logic [31:0] COUNTDOWN_CYC = 32'd300000000,
   parameter logic [31:0] GAME_CYC      = 32'd3000000000,
   parameter logic [31:0] START_MAX     = 32'd100000000,
   parameter logic [31:0] MIN_MAX       = 32'd10000000,
   parameter logic [31:0] STEP          = 32'd5000000,
   parameter logic [31:0] SPEEDUP_SYMS  = 32'd8,
   parameter logic [31:0] WINDOW_CYC    = 32'd50000000
) (
   input  logic        Clk100M,
   input  logic        rst_n,
   input  logic        startBtn,
   input  logic        playerBtn,
   input  logic        generated,
   input  logic        special,
   output logic        genSym,
   output logic [31:0] symGenMax,
   output logic [15:0] score,
   output logic [15:0] misses,
   output logic [1:0]  phase,
   output logic        gameOver
);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_COUNTDOWN = 2'd1,
      ST_PLAY      = 2'd2,
      ST_DONE      = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] timer_q, timer_d;
   logic [31:0] sym_cnt_q, sym_cnt_d;
   logic        win_open_q, win_open_d;
   logic [31:0] win_cnt_q, win_cnt_d;
   logic [31:0] sgm_d;
   logic [15:0] score_d, misses_d;
   logic        hit_evt, miss_evt;
   logic        win_expire;

   assign phase      = state_q;
   assign win_expire = win_open_q && (win_cnt_q == WINDOW_CYC - 32'd1);

   always_ff @(posedge Clk100M or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         timer_q    <= '0;
         sym_cnt_q  <= '0;
         win_open_q <= 1'b0;
         win_cnt_q  <= '0;
         symGenMax  <= START_MAX;
         score      <= '0;
         misses     <= '0;
         genSym     <= 1'b0;
         gameOver   <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         sym_cnt_q  <= sym_cnt_d;
         win_open_q <= win_open_d;
         win_cnt_q  <= win_cnt_d;
         symGenMax  <= sgm_d;
         score      <= score_d;
         misses     <= misses_d;
         genSym     <= (state_d == ST_PLAY);
         gameOver   <= (state_d == ST_DONE);
      end
   end

   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      sym_cnt_d  = sym_cnt_q;
      win_open_d = win_open_q;
      win_cnt_d  = win_cnt_q;
      sgm_d      = symGenMax;
      score_d    = score;
      misses_d   = misses;
      hit_evt    = 1'b0;
      miss_evt   = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (startBtn) begin
               state_d    = ST_COUNTDOWN;
               score_d    = '0;
               misses_d   = '0;
               sgm_d      = START_MAX;
               timer_d    = '0;
               sym_cnt_d  = '0;
               win_open_d = 1'b0;
               win_cnt_d  = '0;
            end
         end
         ST_COUNTDOWN: begin
            if (timer_q == COUNTDOWN_CYC - 32'd1) begin
               state_d = ST_PLAY;
               timer_d = '0;
            end else begin
               timer_d = timer_q + 32'd1;
            end
         end
         ST_PLAY: begin
            // Floor test is done on the difference so the subtraction never wraps.
            if (generated) begin
               if (sym_cnt_q == SPEEDUP_SYMS - 32'd1) begin
                  sym_cnt_d = '0;
                  sgm_d = (symGenMax > MIN_MAX && (symGenMax - MIN_MAX) >= STEP) ?
                          symGenMax - STEP : MIN_MAX;
               end else begin
                  sym_cnt_d = sym_cnt_q + 32'd1;
               end
            end
            // A new special retires an unanswered window as a miss; a press in the
            // same cycle answers the new window.
            if (special) begin
               miss_evt = win_open_q;
               if (playerBtn) begin
                  hit_evt    = 1'b1;
                  win_open_d = 1'b0;
               end else begin
                  win_open_d = 1'b1;
               end
               win_cnt_d = '0;
            end else if (playerBtn) begin
               hit_evt    = win_open_q;
               miss_evt   = !win_open_q;
               win_open_d = 1'b0;
               win_cnt_d  = '0;
            end else if (win_expire) begin
               miss_evt   = 1'b1;
               win_open_d = 1'b0;
               win_cnt_d  = '0;
            end else if (win_open_q) begin
               win_cnt_d = win_cnt_q + 32'd1;
            end
            if (hit_evt && score != 16'hFFFF)
               score_d = score + 16'd1;
            if (miss_evt && misses != 16'hFFFF)
               misses_d = misses + 16'd1;
            if (timer_q == GAME_CYC - 32'd1) begin
               state_d    = ST_DONE;
               timer_d    = '0;
               win_open_d = 1'b0;
               win_cnt_d  = '0;
            end else begin
               timer_d = timer_q + 32'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_sym_game_ctrl.sv
// Directed bench for sym_game_ctrl: a per-cycle PLAY vector table plus
// hand-written sequences for phase timing, ignored pulses, reset and saturation.
module tb_sym_game_ctrl;

   typedef struct {
      logic        gen;
      logic        spec;
      logic        pbtn;
      logic [15:0] exp_score;
      logic [15:0] exp_misses;
      logic [31:0] exp_sgm;
   } play_vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_btn, player_btn, generated, special;
   logic        gen_sym, game_over;
   logic [31:0] sym_gen_max;
   logic [15:0] score, misses;
   logic [1:0]  phase;

   int          checks = 0;
   int          failures = 0;
   logic [63:0] exp_q[$];
   play_vec_t   vecs[30];

   always #5 clk = ~clk;

   sym_game_ctrl #(
      .COUNTDOWN_CYC(32'd10),
      .GAME_CYC     (32'd200),
      .START_MAX    (32'd20),
      .MIN_MAX      (32'd8),
      .STEP         (32'd5),
      .SPEEDUP_SYMS (32'd2),
      .WINDOW_CYC   (32'd4)
   ) dut (
      .Clk100M  (clk),
      .rst_n    (rst_n),
      .startBtn (start_btn),
      .playerBtn(player_btn),
      .generated(generated),
      .special  (special),
      .genSym   (gen_sym),
      .symGenMax(sym_gen_max),
      .score    (score),
      .misses   (misses),
      .phase    (phase),
      .gameOver (game_over)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: drive inputs, take the edge, sample 1 ns later, clear inputs.
   task automatic step(input logic st, input logic g, input logic s, input logic p);
      start_btn  = st;
      generated  = g;
      special    = s;
      player_btn = p;
      @(posedge clk);
      #1;
      start_btn  = 1'b0;
      generated  = 1'b0;
      special    = 1'b0;
      player_btn = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic set_vec(input int i, input logic g, input logic s, input logic p,
                          input int sc, input int ms, input int sg);
      vecs[i].gen        = g;
      vecs[i].spec       = s;
      vecs[i].pbtn       = p;
      vecs[i].exp_score  = 16'(sc);
      vecs[i].exp_misses = 16'(ms);
      vecs[i].exp_sgm    = 32'(sg);
   endtask

   initial begin
      // speed-up 20->15->10->8, floor holds
      set_vec(0, 1, 0, 0, 0, 0, 20);  set_vec(1, 1, 0, 0, 0, 0, 15);
      set_vec(2, 1, 0, 0, 0, 0, 15);  set_vec(3, 1, 0, 0, 0, 0, 10);
      set_vec(4, 1, 0, 0, 0, 0, 10);  set_vec(5, 1, 0, 0, 0, 0, 8);
      set_vec(6, 1, 0, 0, 0, 0, 8);   set_vec(7, 1, 0, 0, 0, 0, 8);
      // hit two cycles after special
      set_vec(8, 0, 1, 0, 0, 0, 8);   set_vec(9, 0, 0, 0, 0, 0, 8);
      set_vec(10, 0, 0, 1, 1, 0, 8);
      // unanswered special expires four cycles later
      set_vec(11, 0, 1, 0, 1, 0, 8);  set_vec(12, 0, 0, 0, 1, 0, 8);
      set_vec(13, 0, 0, 0, 1, 0, 8);  set_vec(14, 0, 0, 0, 1, 0, 8);
      set_vec(15, 0, 0, 0, 1, 1, 8);
      // false press
      set_vec(16, 0, 0, 1, 1, 2, 8);
      // special over open window together with a press
      set_vec(17, 0, 1, 0, 1, 2, 8);  set_vec(18, 0, 0, 0, 1, 2, 8);
      set_vec(19, 0, 1, 1, 2, 3, 8);  set_vec(20, 0, 0, 0, 2, 3, 8);
      // press in the expiry cycle is a hit
      set_vec(21, 0, 1, 0, 2, 3, 8);  set_vec(22, 0, 0, 0, 2, 3, 8);
      set_vec(23, 0, 0, 0, 2, 3, 8);  set_vec(24, 0, 0, 0, 2, 3, 8);
      set_vec(25, 0, 0, 1, 3, 3, 8);  set_vec(26, 0, 0, 0, 3, 3, 8);
      set_vec(27, 0, 0, 0, 3, 3, 8);  set_vec(28, 0, 0, 0, 3, 3, 8);
      set_vec(29, 0, 0, 0, 3, 3, 8);

      rst_n = 1'b0;
      start_btn = 1'b0; player_btn = 1'b0; generated = 1'b0; special = 1'b0;
      @(posedge clk);
      #1;
      check("reset_phase", 64'(phase), 64'd0);
      check("reset_gensym", 64'(gen_sym), 64'd0);
      check("reset_sgm", 64'(sym_gen_max), 64'd20);
      check("reset_score", 64'(score), 64'd0);
      check("reset_misses", 64'(misses), 64'd0);
      check("reset_gameover", 64'(game_over), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // pulses in IDLE are ignored
      step(1'b0, 1'b1, 1'b1, 1'b1);
      check("idle_phase", 64'(phase), 64'd0);
      check("idle_counts", {32'(score), 32'(misses)}, 64'd0);
      check("idle_sgm", 64'(sym_gen_max), 64'd20);

      step(1'b1, 1'b0, 1'b0, 1'b0);
      check("start_phase", 64'(phase), 64'd1);
      idle(2);
      // start and player pulses in COUNTDOWN are ignored
      step(1'b1, 1'b1, 1'b1, 1'b1);
      check("cd_counts", {32'(score), 32'(misses)}, 64'd0);
      check("cd_phase", 64'(phase), 64'd1);
      idle(6);
      check("cd_last_phase", 64'(phase), 64'd1);
      check("cd_last_gensym", 64'(gen_sym), 64'd0);
      idle(1);
      check("play_phase", 64'(phase), 64'd2);
      check("play_gensym", 64'(gen_sym), 64'd1);
      check("play_gameover", 64'(game_over), 64'd0);

      for (int i = 0; i < 30; i++) begin
         exp_q.push_back({vecs[i].exp_score, vecs[i].exp_misses, vecs[i].exp_sgm});
         step(1'b0, vecs[i].gen, vecs[i].spec, vecs[i].pbtn);
         check($sformatf("vec%0d", i), {score, misses, sym_gen_max}, exp_q.pop_front());
      end

      // 30 of 200 PLAY edges used; last PLAY cycle carries a special
      idle(169);
      check("play_end_phase", 64'(phase), 64'd2);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      check("done_phase", 64'(phase), 64'd3);
      check("done_gensym", 64'(gen_sym), 64'd0);
      check("done_gameover", 64'(game_over), 64'd1);
      check("done_counts", {32'(score), 32'(misses)}, {32'd3, 32'd3});
      idle(5);
      check("discard_window", {32'(score), 32'(misses)}, {32'd3, 32'd3});
      step(1'b0, 1'b1, 1'b1, 1'b1);
      check("done_ignored", {32'(score), 32'(misses)}, {32'd3, 32'd3});
      check("done_sgm", 64'(sym_gen_max), 64'd8);

      // restart from DONE clears everything
      step(1'b1, 1'b0, 1'b0, 1'b0);
      check("restart_phase", 64'(phase), 64'd1);
      check("restart_counts", {32'(score), 32'(misses)}, 64'd0);
      check("restart_sgm", 64'(sym_gen_max), 64'd20);
      check("restart_gameover", 64'(game_over), 64'd0);
      idle(10);
      check("replay_phase", 64'(phase), 64'd2);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      check("replay_sgm", 64'(sym_gen_max), 64'd15);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
      check("replay_score", {32'(score), 32'(misses)}, {32'd3, 32'd0});

      // asynchronous reset between clock edges
      #3;
      rst_n = 1'b0;
      #1;
      check("areset_phase", 64'(phase), 64'd0);
      check("areset_score", 64'(score), 64'd0);
      check("areset_sgm", 64'(sym_gen_max), 64'd20);
      check("areset_gensym", 64'(gen_sym), 64'd0);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      step(1'b1, 1'b0, 1'b0, 1'b0);
      idle(10);
      check("sat_play_phase", 64'(phase), 64'd2);

      // saturation
      force dut.score = 16'hFFFF;
      #1;
      release dut.score;
      step(1'b0, 1'b0, 1'b1, 1'b1);
      check("sat_score", {32'(score), 32'(misses)}, {32'h0000FFFF, 32'd0});
      step(1'b0, 1'b0, 1'b0, 1'b1);
      check("sat_false_press", {32'(score), 32'(misses)}, {32'h0000FFFF, 32'd1});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
